// File: rtl/level_display.sv
// level_display: four-digit multiplexed seven-segment driver for the
// output-level ratio readout. Digits are snapshotted into shadow registers
// at a fixed update rate and scanned one slot at a time with a dead cycle
// at the start of each slot.
module level_display #(
    parameter int SCAN_DIV   = 48,
    parameter int UPDATE_DIV = 12000,
    parameter int DP_POS     = 3
) (
    input  logic       clk_48,
    input  logic       reset,
    input  logic [3:0] num3,
    input  logic [3:0] num2,
    input  logic [3:0] num1,
    input  logic [3:0] num0,
    input  logic       hold,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int UW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [UW-1:0] UPD_LAST  = UW'(UPDATE_DIV - 1);
    localparam logic [1:0]    DP_IDX    = 2'(DP_POS);

    logic [SW-1:0] scan_cnt;
    logic [UW-1:0] upd_cnt;
    logic [1:0]    idx;
    logic [3:0]    sh [4];
    logic [3:0]    blank;
    logic [3:0]    cur;
    logic          higher_zero;
    logic [1:0]    pos;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Snapshot counter and shadow registers; hold only matters on the snapshot cycle
    always_ff @(posedge clk_48) begin
        if (reset) begin
            upd_cnt <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                sh[i] <= '0;
            end
        end else begin
            if (upd_cnt == UPD_LAST) begin
                upd_cnt <= '0;
            end else begin
                upd_cnt <= upd_cnt + 1'b1;
            end
            if (upd_cnt == UPD_LAST && !hold) begin
                sh[3] <= num3;
                sh[2] <= num2;
                sh[1] <= num1;
                sh[0] <= num0;
            end
        end
    end

    // Slot position counter and digit index
    always_ff @(posedge clk_48) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Leading-zero blanking: walk from the top digit down, only left of the decimal point
    always_comb begin
        blank       = '0;
        higher_zero = 1'b1;
        pos         = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            pos = 2'(3 - k);
            if (sh[pos] != 4'd0) begin
                higher_zero = 1'b0;
            end
            if ((3 - int'(k)) > DP_POS && higher_zero) begin
                blank[pos] = 1'b1;
            end
        end
        cur = sh[idx];
    end

    // Registered display outputs; slot position 0 is dead time
    always_ff @(posedge clk_48) begin
        if (reset) begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
        end else if (scan_cnt == '0) begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= blank[idx] ? 7'b1111111 : decode(cur);
            dp  <= (idx == DP_IDX) ? 1'b0 : 1'b1;
        end
    end

endmodule

// File: tb/tb_level_display.sv
// Testbench for level_display: three instances with different parameter sets
// share stimulus; a per-instance behavioural model predicts every cycle.
module tb_level_display;

    logic clk_48 = 1'b0;
    always #5 clk_48 = ~clk_48;

    logic       reset;
    logic [3:0] num3, num2, num1, num0;
    logic       hold;
    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] an_a, an_b, an_c;

    level_display #(.SCAN_DIV(4), .UPDATE_DIV(16), .DP_POS(3)) dut_a (
        .clk_48(clk_48), .reset(reset), .num3(num3), .num2(num2), .num1(num1),
        .num0(num0), .hold(hold), .seg(seg_a), .dp(dp_a), .an(an_a));

    level_display #(.SCAN_DIV(4), .UPDATE_DIV(16), .DP_POS(0)) dut_b (
        .clk_48(clk_48), .reset(reset), .num3(num3), .num2(num2), .num1(num1),
        .num0(num0), .hold(hold), .seg(seg_b), .dp(dp_b), .an(an_b));

    level_display #(.SCAN_DIV(2), .UPDATE_DIV(1), .DP_POS(1)) dut_c (
        .clk_48(clk_48), .reset(reset), .num3(num3), .num2(num2), .num1(num1),
        .num0(num0), .hold(hold), .seg(seg_c), .dp(dp_c), .an(an_c));

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int checks = 0;
    int errors = 0;

    int S [3] = '{4, 4, 2};
    int U [3] = '{16, 16, 1};
    int D [3] = '{3, 0, 1};
    int n [3];
    logic [3:0] msh [3][4];
    logic [6:0] dec [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    task automatic set_in(input int a3, input int a2, input int a1, input int a0);
        num3 = 4'(a3);
        num2 = 4'(a2);
        num1 = 4'(a1);
        num0 = 4'(a0);
    endtask

    // Predict the outputs of the coming edge for each instance, then advance one cycle
    task automatic step();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            int p, ix;
            logic blanked;
            e = '{4'hF, 7'h7F, 1'b1};
            if (reset) begin
                n[k] = 0;
                for (int j = 0; j < 4; j++) msh[k][j] = 4'd0;
            end else begin
                n[k]++;
                p  = (n[k] - 1) % S[k];
                ix = ((n[k] - 1) / S[k]) % 4;
                if (p != 0) begin
                    blanked = (ix > D[k]);
                    for (int j = ix; j < 4; j++) begin
                        if (msh[k][j] != 4'd0) blanked = 1'b0;
                    end
                    e.an     = 4'hF;
                    e.an[ix] = 1'b0;
                    e.seg    = blanked ? 7'h7F : dec[msh[k][ix]];
                    e.dp     = (ix == D[k]) ? 1'b0 : 1'b1;
                end
                if ((n[k] % U[k]) == 0 && !hold) begin
                    msh[k][3] = num3;
                    msh[k][2] = num2;
                    msh[k][1] = num1;
                    msh[k][0] = num0;
                end
            end
            case (k)
                0:       q_a.push_back(e);
                1:       q_b.push_back(e);
                default: q_c.push_back(e);
            endcase
        end
        @(posedge clk_48);
        @(negedge clk_48);
    endtask

    task automatic check(input string nm, input exp_t e, input logic [3:0] an,
                         input logic [6:0] seg, input logic dp);
        checks++;
        if (an !== e.an) begin
            errors++;
            $display("FAIL %s an t=%0t got %b exp %b", nm, $time, an, e.an);
        end
        checks++;
        if (dp !== e.dp) begin
            errors++;
            $display("FAIL %s dp t=%0t got %b exp %b", nm, $time, dp, e.dp);
        end
        if (e.an != 4'hF) begin
            checks++;
            if (seg !== e.seg) begin
                errors++;
                $display("FAIL %s seg t=%0t got %b exp %b", nm, $time, seg, e.seg);
            end
        end
    endtask

    // Monitor: compare each instance's registered outputs just after every edge
    always @(posedge clk_48) begin
        #1;
        if (q_a.size() > 0) check("A", q_a.pop_front(), an_a, seg_a, dp_a);
        if (q_b.size() > 0) check("B", q_b.pop_front(), an_b, seg_b, dp_b);
        if (q_c.size() > 0) check("C", q_c.pop_front(), an_c, seg_c, dp_c);
    end

    initial begin
        int tries;
        reset = 1'b1;
        hold  = 1'b0;
        set_in(0, 0, 0, 0);
        @(negedge clk_48);
        step();
        step();
        reset = 1'b0;

        set_in(1, 2, 3, 4);
        repeat (40) step();
        set_in(0, 0, 4, 7);
        repeat (40) step();
        set_in(0, 0, 0, 0);
        repeat (40) step();
        set_in(0, 0, 12, 5);
        repeat (40) step();

        set_in(9, 9, 9, 9);
        repeat (20) step();
        hold = 1'b1;
        set_in(1, 1, 1, 1);
        repeat (48) step();
        hold = 1'b0;
        repeat (20) step();

        // Reset while instance A is in the enabled part of the digit-3 slot
        tries = 0;
        while (tries < 32 && !((((n[0] - 1) / 4) % 4) == 3 && ((n[0] - 1) % 4) != 0)) begin
            step();
            tries++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_in(3, 0, 0, 8);
        repeat (40) step();

        repeat (1500) begin
            num3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            num2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            num1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            num0 = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        hold  = 1'b0;
        step();

        @(posedge clk_48);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
